// File: rtl/mem_arb_pkg.sv
// -----------------------------------------------------------------------------
// mem_arb_pkg
//   Shared types and constants for the two-port memory arbiter.
//   - state_t    : arbiter sequencing states (IDLE, ACCESS, RESP)
//   - mem_req_t  : one requester's transaction fields, latched at grant
//   - SZ_*       : memory access size encodings
//   - PORT_*     : requester port indices
// -----------------------------------------------------------------------------
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        sign;
    } mem_req_t;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int PORT_CPU = 0;
    localparam int PORT_DBG = 1;

    // Select one port's transaction fields.
    function automatic mem_req_t pick_req(input logic sel_dbg,
                                          input mem_req_t r_cpu,
                                          input mem_req_t r_dbg);
        return sel_dbg ? r_dbg : r_cpu;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
//   Combinational two-way round-robin pick.
//   Ports:
//     req        in  [1:0]  per-port request
//     last_owner in  1      port granted most recently (owned by the caller)
//     grant      out [1:0]  one-hot grant, zero when no request
//   With both ports requesting, the port that did not win last time wins.
// -----------------------------------------------------------------------------
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic [1:0] grant
);

    // NOTE: every output of a combinational block gets a default before the
    // case so no path leaves it unassigned, which would infer a latch.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = (last_owner == 1'b1) ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Round-robin arbiter sharing one synchronous memory port between the CPU
//   memory interface (port 0) and a debug/DMA loader (port 1). A granted
//   transaction is latched, held on the memory port for MEM_LAT cycles, and
//   answered with a one-cycle ack carrying read data and the error flag.
//
//   Parameters:
//     MEM_LAT  memory latency in cycles (>= 1)
//   Ports:
//     clk, rst                     clock, async active-low reset
//     req/we [1:0]                 per-port request and write enable
//     addr*/wdata*/size*/sign*     per-port transaction fields
//     ack [1:0], rdata, err        one-hot completion pulse, read data, error
//     busy                         high outside IDLE
//     mem_we/addr/data/size/sign   memory request port
//     mem_out, mem_error           memory response
//
//   Timing: request sampled in IDLE at cycle N -> ACCESS cycles N+1..N+MEM_LAT
//   -> ack in cycle N+MEM_LAT+1 -> IDLE again, so one transaction takes
//   MEM_LAT+2 cycles.
// -----------------------------------------------------------------------------
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MEM_LAT = 1
)(
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  req,
    input  logic [1:0]  we,
    input  logic [31:0] addr0,
    input  logic [31:0] addr1,
    input  logic [31:0] wdata0,
    input  logic [31:0] wdata1,
    input  logic [1:0]  size0,
    input  logic [1:0]  size1,
    input  logic        sign0,
    input  logic        sign1,
    output logic [1:0]  ack,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data,
    output logic [1:0]  mem_size,
    output logic        mem_sign,
    input  logic [31:0] mem_out,
    input  logic        mem_error
);

    localparam int                CNT_W    = $clog2(MEM_LAT + 1);
    localparam logic [CNT_W-1:0]  CNT_INIT = CNT_W'(MEM_LAT - 1);

    state_t           state;
    logic             last_owner;
    logic             owner;        // 0 = CPU, 1 = debug/DMA
    logic             first_cycle;  // high only during the first ACCESS cycle
    logic [CNT_W-1:0] cnt;
    mem_req_t         cur;          // transaction latched at grant

    logic [1:0]       grant;
    mem_req_t         req_cpu;
    mem_req_t         req_dbg;
    mem_req_t         req_sel;

    assign req_cpu = '{we: we[PORT_CPU], addr: addr0, wdata: wdata0,
                       size: size0, sign: sign0};
    assign req_dbg = '{we: we[PORT_DBG], addr: addr1, wdata: wdata1,
                       size: size1, sign: sign1};

    rr_arb2 u_rr_arb2 (
        .req        (req),
        .last_owner (last_owner),
        .grant      (grant)
    );

    assign req_sel = pick_req(grant[PORT_DBG], req_cpu, req_dbg);

    // The memory port is driven straight from the latched transaction, so
    // requester fields changing after grant never reach the memory. The write
    // strobe is qualified by the first ACCESS cycle to give one pulse per
    // write; both terms clear asynchronously so mem_we drops with reset.
    assign mem_we   = cur.we & first_cycle;
    assign mem_addr = cur.addr;
    assign mem_data = cur.wdata;
    assign mem_size = cur.size;
    assign mem_sign = cur.sign;

    // NOTE: state is written with non-blocking assignments so every register
    // in this block sees the pre-edge values of the others.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_owner  <= 1'b1;   // port 0 wins the first contended grant
            owner       <= 1'b0;
            first_cycle <= 1'b0;
            cnt         <= '0;
            cur         <= '0;
            ack         <= 2'b00;
            rdata       <= '0;
            err         <= 1'b0;
            busy        <= 1'b0;
        end else begin
            ack         <= 2'b00;
            first_cycle <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (|req) begin
                        // grant is one-hot here; both bits feed the owner so
                        // a malformed grant cannot pick port 1 by accident.
                        owner       <= grant[PORT_DBG] & ~grant[PORT_CPU];
                        last_owner  <= grant[PORT_DBG] & ~grant[PORT_CPU];
                        cur         <= req_sel;
                        first_cycle <= 1'b1;
                        cnt         <= CNT_INIT;
                        busy        <= 1'b1;
                        state       <= ACCESS;
                    end
                end

                ACCESS: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rdata <= mem_out;
                        err   <= mem_error;
                        ack   <= owner ? 2'b10 : 2'b01;
                        state <= RESP;
                    end
                end

                RESP: begin
                    // Requests are not sampled here; the requester re-presents
                    // or drops req for the following IDLE cycle.
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two instances share the requester inputs
//   and reset: dut_a with MEM_LAT=1 and dut_b with MEM_LAT=3. Each has its own
//   combinational memory model. Inputs change on the falling edge, outputs are
//   sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;
    import mem_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [1:0]  we = 2'b00;
    logic [31:0] addr0 = '0, addr1 = '0, wdata0 = '0, wdata1 = '0;
    logic [1:0]  size0 = SZ_WORD, size1 = SZ_WORD;
    logic        sign0 = 1'b0, sign1 = 1'b0;

    logic [1:0]  ack_a, ack_b;
    logic [31:0] rdata_a, rdata_b;
    logic        err_a, err_b, busy_a, busy_b;
    logic        mem_we_a, mem_we_b;
    logic [31:0] mem_addr_a, mem_addr_b, mem_data_a, mem_data_b;
    logic [1:0]  mem_size_a, mem_size_b;
    logic        mem_sign_a, mem_sign_b;
    logic [31:0] mem_out_a, mem_out_b;
    logic        mem_error_a, mem_error_b;

    int checks = 0;
    int errors = 0;
    int we_pulses_a = 0;

    always #5 clk = ~clk;

    // Memory model: one fixed word at 0x100, a recognisable pattern elsewhere;
    // misaligned half/word accesses flag an error.
    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hDEAD_BEEF;
        return a ^ 32'hA5A5_0000;
    endfunction

    function automatic logic misaligned(input logic [31:0] a, input logic [1:0] s);
        if (s == SZ_HALF) return a[0];
        if (s == SZ_WORD) return (a[1:0] != 2'b00);
        return 1'b0;
    endfunction

    always_comb begin
        mem_out_a   = mem_rd(mem_addr_a);
        mem_error_a = misaligned(mem_addr_a, mem_size_a);
        mem_out_b   = mem_rd(mem_addr_b);
        mem_error_b = misaligned(mem_addr_b, mem_size_b);
    end

    always @(negedge clk) if (mem_we_a) we_pulses_a++;

    mem_arbiter #(.MEM_LAT(1)) dut_a (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1), .sign0(sign0), .sign1(sign1),
        .ack(ack_a), .rdata(rdata_a), .err(err_a), .busy(busy_a),
        .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_data(mem_data_a),
        .mem_size(mem_size_a), .mem_sign(mem_sign_a),
        .mem_out(mem_out_a), .mem_error(mem_error_a)
    );

    mem_arbiter #(.MEM_LAT(3)) dut_b (
        .clk(clk), .rst(rst), .req(req), .we(we),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .size0(size0), .size1(size1), .sign0(sign0), .sign1(sign1),
        .ack(ack_b), .rdata(rdata_b), .err(err_b), .busy(busy_b),
        .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_data(mem_data_b),
        .mem_size(mem_size_b), .mem_sign(mem_sign_b),
        .mem_out(mem_out_b), .mem_error(mem_error_b)
    );

    task automatic tick;
        @(negedge clk);
    endtask

    // Leaves the bench on a falling edge with one idle cycle after release;
    // the caller's next req assignment lands in "cycle 0".
    task automatic do_reset;
        rst = 1'b0; req = 2'b00; we = 2'b00;
        size0 = SZ_WORD; size1 = SZ_WORD;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_reset;
        #2 rst = 1'b0;
        #1;
        checks++; if (ack_a !== 2'b00 || ack_b !== 2'b00) begin errors++; $display("FAIL reset_ack got %b/%b expected 00", ack_a, ack_b); end
        checks++; if (busy_a !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL reset_busy got %b/%b expected 0", busy_a, busy_b); end
        checks++; if (mem_we_a !== 1'b0 || mem_we_b !== 1'b0) begin errors++; $display("FAIL reset_mem_we got %b/%b expected 0", mem_we_a, mem_we_b); end
        checks++; if (mem_addr_a !== 32'h0 || mem_data_a !== 32'h0 || mem_size_a !== 2'b00 || mem_sign_a !== 1'b0) begin errors++; $display("FAIL reset_mem_port got %h %h %b %b expected zeros", mem_addr_a, mem_data_a, mem_size_a, mem_sign_a); end
        checks++; if (rdata_a !== 32'h0 || err_a !== 1'b0) begin errors++; $display("FAIL reset_rdata_err got %h %b expected 0 0", rdata_a, err_a); end
        tick();
        rst = 1'b1;
        tick();
    endtask

    task automatic test_cpu_read;
        int p0;
        do_reset();
        addr0 = 32'h100; size0 = SZ_WORD; we = 2'b00; req = 2'b01;
        p0 = we_pulses_a;
        tick(); // cycle 1: ACCESS
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL read_busy got %b expected 1", busy_a); end
        checks++; if (mem_addr_a !== 32'h100) begin errors++; $display("FAIL read_mem_addr got %h expected 00000100", mem_addr_a); end
        checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL read_early_ack got %b expected 00", ack_a); end
        tick(); // cycle 2: RESP
        checks++; if (ack_a !== 2'b01) begin errors++; $display("FAIL read_ack got %b expected 01", ack_a); end
        checks++; if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL read_rdata got %h expected deadbeef", rdata_a); end
        checks++; if (err_a !== 1'b0) begin errors++; $display("FAIL read_err got %b expected 0", err_a); end
        req = 2'b00;
        tick(); // cycle 3: IDLE
        checks++; if (ack_a !== 2'b00 || busy_a !== 1'b0) begin errors++; $display("FAIL read_idle got ack %b busy %b expected 00 0", ack_a, busy_a); end
        #1;
        checks++; if (we_pulses_a != p0) begin errors++; $display("FAIL read_no_write got %0d pulses expected 0", we_pulses_a - p0); end
    endtask

    task automatic test_simultaneous;
        logic [1:0] exp;
        do_reset();
        addr0 = 32'h100; addr1 = 32'h204; req = 2'b11;
        for (int c = 1; c <= 6; c++) begin
            tick();
            exp = (c == 2) ? 2'b01 : (c == 5) ? 2'b10 : 2'b00;
            checks++; if (ack_a !== exp) begin errors++; $display("FAIL simul_ack cycle %0d got %b expected %b", c, ack_a, exp); end
            if (c == 2) begin
                checks++; if (rdata_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL simul_rdata0 got %h expected deadbeef", rdata_a); end
                req[0] = 1'b0;
            end
            if (c == 5) begin
                checks++; if (rdata_a !== 32'hA5A5_0204) begin errors++; $display("FAIL simul_rdata1 got %h expected a5a50204", rdata_a); end
                req[1] = 1'b0;
            end
        end
    endtask

    task automatic test_back_to_back;
        logic [1:0]  exp;
        logic [31:0] exp_data;
        logic        next_dbg;
        do_reset();
        addr0 = 32'h100; addr1 = 32'h204; req = 2'b11;
        next_dbg = 1'b0;
        for (int c = 1; c <= 24; c++) begin
            tick();
            if (c % 3 == 2) begin
                exp      = next_dbg ? 2'b10 : 2'b01;
                exp_data = next_dbg ? 32'hA5A5_0204 : 32'hDEAD_BEEF;
                next_dbg = ~next_dbg;
                checks++; if (ack_a !== exp || rdata_a !== exp_data) begin errors++; $display("FAIL rr_ack cycle %0d got %b/%h expected %b/%h", c, ack_a, rdata_a, exp, exp_data); end
            end else begin
                checks++; if (ack_a !== 2'b00) begin errors++; $display("FAIL rr_no_ack cycle %0d got %b expected 00", c, ack_a); end
            end
            if (c % 3 == 0) begin
                checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL rr_idle_gap cycle %0d got busy %b expected 0", c, busy_a); end
            end
        end
        req = 2'b00;
    endtask

    task automatic test_write_error;
        int p0;
        do_reset();
        p0 = we_pulses_a;
        we = 2'b10; addr1 = 32'h203; wdata1 = 32'h1234_5678; size1 = SZ_WORD; req = 2'b10;
        tick(); // cycle 1
        checks++; if (mem_we_a !== 1'b1) begin errors++; $display("FAIL wr_pulse got %b expected 1", mem_we_a); end
        checks++; if (mem_addr_a !== 32'h203 || mem_data_a !== 32'h1234_5678 || mem_size_a !== SZ_WORD) begin errors++; $display("FAIL wr_fields got %h %h %b expected 00000203 12345678 10", mem_addr_a, mem_data_a, mem_size_a); end
        tick(); // cycle 2
        checks++; if (mem_we_a !== 1'b0) begin errors++; $display("FAIL wr_pulse_end got %b expected 0", mem_we_a); end
        checks++; if (ack_a !== 2'b10 || err_a !== 1'b1) begin errors++; $display("FAIL wr_err_ack got %b err %b expected 10 1", ack_a, err_a); end
        req = 2'b00;
        tick(); // cycle 3: IDLE, present aligned write
        addr1 = 32'h200; wdata1 = 32'hCAFE_F00D; req = 2'b10;
        tick(); // cycle 4
        checks++; if (mem_we_a !== 1'b1 || mem_data_a !== 32'hCAFE_F00D) begin errors++; $display("FAIL wr2_pulse got %b %h expected 1 cafef00d", mem_we_a, mem_data_a); end
        tick(); // cycle 5
        checks++; if (ack_a !== 2'b10 || err_a !== 1'b0) begin errors++; $display("FAIL wr2_ack got %b err %b expected 10 0", ack_a, err_a); end
        req = 2'b00; we = 2'b00;
        tick();
        #1;
        checks++; if (we_pulses_a - p0 != 2) begin errors++; $display("FAIL wr_pulse_count got %0d expected 2", we_pulses_a - p0); end
    endtask

    task automatic test_reset_mid_access;
        logic       saw_ack;
        logic [1:0] exp;
        // Write aborted in its first ACCESS cycle: strobe must drop at once.
        do_reset();
        we = 2'b01; addr0 = 32'h100; wdata0 = 32'h1; req = 2'b01;
        tick();
        checks++; if (mem_we_b !== 1'b1) begin errors++; $display("FAIL mid_wr_pulse got %b expected 1", mem_we_b); end
        rst = 1'b0; req = 2'b00; we = 2'b00;
        #1;
        checks++; if (mem_we_b !== 1'b0 || busy_b !== 1'b0) begin errors++; $display("FAIL mid_async_drop got we %b busy %b expected 0 0", mem_we_b, busy_b); end
        tick();
        rst = 1'b1;
        tick();
        // Read by port 0 aborted in its second ACCESS cycle.
        addr0 = 32'h100; addr1 = 32'h204; req = 2'b01;
        tick();
        tick();
        checks++; if (busy_b !== 1'b1 || ack_b !== 2'b00) begin errors++; $display("FAIL mid_pre busy %b ack %b expected 1 00", busy_b, ack_b); end
        rst = 1'b0; req = 2'b00;
        #1;
        checks++; if (busy_b !== 1'b0 || mem_we_b !== 1'b0 || ack_b !== 2'b00) begin errors++; $display("FAIL mid_abort busy %b we %b ack %b expected 0 0 00", busy_b, mem_we_b, ack_b); end
        tick();
        rst = 1'b1;
        saw_ack = 1'b0;
        for (int c = 0; c < 6; c++) begin
            tick();
            if (ack_b !== 2'b00) saw_ack = 1'b1;
        end
        checks++; if (saw_ack !== 1'b0) begin errors++; $display("FAIL mid_no_ack got ack seen %b expected 0", saw_ack); end
        req = 2'b11;
        for (int c = 1; c <= 4; c++) begin
            tick();
            exp = (c == 4) ? 2'b01 : 2'b00;
            checks++; if (ack_b !== exp) begin errors++; $display("FAIL mid_regrant cycle %0d got %b expected %b", c, ack_b, exp); end
        end
        checks++; if (rdata_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL mid_regrant_rdata got %h expected deadbeef", rdata_b); end
        req = 2'b00;
    endtask

    task automatic test_latency;
        do_reset();
        addr0 = 32'h300; req = 2'b01;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++; if (mem_addr_b !== 32'h300 || busy_b !== 1'b1 || ack_b !== 2'b00) begin errors++; $display("FAIL lat_access cycle %0d got addr %h busy %b ack %b expected 00000300 1 00", c, mem_addr_b, busy_b, ack_b); end
        end
        tick(); // cycle 4
        checks++; if (ack_b !== 2'b01 || rdata_b !== 32'hA5A5_0300) begin errors++; $display("FAIL lat_ack got %b %h expected 01 a5a50300", ack_b, rdata_b); end
        req = 2'b00;
        tick(); // cycle 5
        checks++; if (ack_b !== 2'b00 || busy_b !== 1'b0) begin errors++; $display("FAIL lat_idle got ack %b busy %b expected 00 0", ack_b, busy_b); end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_simultaneous();
        test_back_to_back();
        test_write_error();
        test_reset_mid_access();
        test_latency();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-requester, round-robin arbiter that shares the single synchronous memory port between the CPU memory interface (port 0) and a debug/DMA loader (port 1).
- Each transaction is latched and sequenced through a fixed-latency memory access. The requester gets a one-cycle ack with read data or error.
- Sits between the CPU datapath/control unit and the memory module.

Parameters:
- MEM_LAT, 1, memory access latency in cycles (>=1); read data and error are valid MEM_LAT cycles after the address is presented.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- req  in  [1:0]  per-port request; held high with fields stable until that port's ack
- we  in  [1:0]  per-port write enable (1 = write)
- addr0, addr1  in  32  per-port byte address
- wdata0, wdata1  in  32  per-port write data
- size0, size1  in  2  per-port access size (00 byte, 01 half, 10 word)
- sign0, sign1  in  1  per-port load sign-extend (1 = unsigned, memory encoding)
- ack  out  [1:0]  one-hot, one-cycle transaction-complete pulse
- rdata  out  32  read data, valid only while an ack bit is high
- err  out  1  memory error for the acked transaction, valid with ack
- busy  out  1  arbiter not in IDLE
- mem_we  out  1  memory write enable
- mem_addr  out  32  memory address
- mem_data  out  32  memory write data
- mem_size  out  2  memory size
- mem_sign  out  1  memory sign
- mem_out  in  32  memory read data
- mem_error  in  1  memory error flag

Behaviour:
- Reset (rst low, asynchronous): state=IDLE; ack=0, err=0, rdata=0, busy=0; mem_we=0, mem_addr/data/size/sign=0; last_owner=1 (port 0 wins first). mem_we must drop immediately, without waiting for a clock.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - If any req bit is high: pick the owner, latch that port's we/addr/wdata/size/sign into registers, load cnt=MEM_LAT-1, go to ACCESS.
  - Otherwise stay in IDLE.
- Arbitration:
  - Single requester: it wins.
  - Both requesting: the port != last_owner wins.
  - last_owner is updated on the grant edge.
- ACCESS:
  - mem_addr/data/size/sign are driven from the latched registers.
  - mem_we = latched we AND first ACCESS cycle only, giving exactly one write pulse per transaction.
  - While cnt!=0: decrement cnt.
  - When cnt==0: capture mem_out into rdata and mem_error into err on that edge, go to RESP.
- RESP:
  - ack[owner]=1 for exactly one cycle; rdata/err held from the capture.
  - Next state is always IDLE; req is not sampled in RESP.
  - The requester drops or re-presents req on the cycle after ack.
- Latency: req sampled in IDLE at cycle N -> ack at cycle N+MEM_LAT+1. Minimum request-to-request spacing is MEM_LAT+2 cycles.
- Write transactions: ack still issued. rdata equals the mem_out capture and is don't-care to the requester. err reflects mem_error (e.g. misaligned write).
- Port fields: a requester's fields changing while not owner has no effect. Changes while owner are ignored, because the fields are latched at grant.
- busy: high in ACCESS and RESP.
- Reset mid-ACCESS: the transaction is aborted, no ack is generated, and the arbiter returns to IDLE with last_owner=1.
- ack is never asserted for a port whose req was low at grant.
- ack bits are never both high.
- Width rules: cnt is $clog2(MEM_LAT+1) bits wide. No arithmetic on address or data; addr and data pass through unchanged.

Decomposition:
- Package mem_arb_pkg:
  - state enum (IDLE, ACCESS, RESP)
  - mem_req_t struct (we, addr, wdata, size, sign)
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD
  - PORT_CPU=0, PORT_DBG=1
- Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], last_owner -> grant one-hot). The main module owns the last_owner register.

Test Plan:
- CPU read (MEM_LAT=1): req=01, addr0=0x100, size0=10, memory[0x100]=0xDEADBEEF -> mem_addr=0x100 in cycle 1, ack=01 in cycle 2, rdata=0xDEADBEEF, err=0, mem_we never high.
- Simultaneous after reset: req=11 -> port 0 acked first. Port 1 is granted on the following IDLE and acked at cycle 5 relative to the first sample. rdata matches each port's address.
- Continuous contention: both ports hold req for 8 transactions -> acks strictly alternate 01,10,01,10,... with one IDLE cycle between RESP and the next grant.
- Write pulse and error: port 1 write, addr1=0x203, wdata1=0x12345678, size1=10, memory asserts mem_error -> mem_we high for exactly one cycle, ack=10, err=1. A subsequent aligned write gives err=0.
- Reset mid-access: MEM_LAT=3, assert rst low during the second ACCESS cycle -> mem_we and busy are 0 immediately, no ack. After release, req=11 grants port 0 first.
- Latency parameter: MEM_LAT=3 single read -> ack exactly 4 cycles after req is sampled, and mem_addr is stable for all 3 ACCESS cycles.
